// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size select encodings, byte counts, loader FSM states
// and the key-size helper functions used by the loader and the AES core.
package aes_pkg;

    localparam logic [1:0] SEL_128 = 2'b00;
    localparam logic [1:0] SEL_192 = 2'b01;
    localparam logic [1:0] SEL_256 = 2'b10;

    localparam int unsigned KEY128_BYTES = 16;
    localparam int unsigned KEY192_BYTES = 24;
    localparam int unsigned KEY256_BYTES = 32;
    localparam int unsigned DATA_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        HOLD
    } loader_state_e;

    // Both 2'b10 and 2'b11 select a 256-bit key.
    function automatic logic [5:0] key_bytes(input logic [1:0] s);
        case (s)
            SEL_128: key_bytes = 6'(KEY128_BYTES);
            SEL_192: key_bytes = 6'(KEY192_BYTES);
            default: key_bytes = 6'(KEY256_BYTES);
        endcase
    endfunction

    function automatic logic [3:0] num_rounds(input logic [1:0] s);
        case (s)
            SEL_128: num_rounds = 4'd10;
            SEL_192: num_rounds = 4'd12;
            default: num_rounds = 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-serial loader that assembles an AES key (16/24/32 bytes) plus a 16-byte
// block MSB-first and hands the bundle to the AES core over valid/ready.
module aes_block_loader #(
    parameter int unsigned DATA_BYTES    = 16,
    parameter int unsigned KEY_MAX_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   sel,
    input  logic                         reuse_key,
    input  logic                         flush,
    input  logic [7:0]                   in_byte,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [8*DATA_BYTES-1:0]      out_data,
    output logic [8*KEY_MAX_BYTES-1:0]   out_key,
    output logic [1:0]                   out_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         key_loaded
);

    import aes_pkg::*;

    loader_state_e                state_q, state_d;
    logic [5:0]                   cnt_q, cnt_d;
    logic [8*DATA_BYTES-1:0]      data_q, data_d;
    logic [8*KEY_MAX_BYTES-1:0]   key_q, key_d;
    logic [1:0]                   sel_q, sel_d;
    logic                         valid_q, valid_d;
    logic                         kl_q, kl_d;
    logic                         accept;
    logic                         key_last;
    logic                         data_last;
    logic                         reuse_hit;

    assign accept    = in_valid & in_ready & ~flush;
    assign key_last  = (cnt_q == key_bytes(sel_q) - 6'd1);
    assign data_last = (cnt_q == 6'(DATA_BYTES - 1));
    assign reuse_hit = reuse_key & kl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            kl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            kl_q    <= kl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    cnt_d   = 6'd1;
                    state_d = reuse_hit ? LOAD_DATA : LOAD_KEY;
                end
                LOAD_KEY: if (accept) begin
                    cnt_d   = key_last ? 6'd0 : cnt_q + 6'd1;
                    state_d = key_last ? LOAD_DATA : LOAD_KEY;
                end
                LOAD_DATA: if (accept) begin
                    cnt_d   = data_last ? 6'd0 : cnt_q + 6'd1;
                    state_d = data_last ? HOLD : LOAD_DATA;
                end
                HOLD: if (valid_q && out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte lanes are written in place; lane index counts down from the MSB.
    always_comb begin
        in_ready = (state_q != HOLD);
        data_d   = data_q;
        key_d    = key_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        kl_d     = kl_q;
        if (flush) begin
            valid_d = 1'b0;
            if (state_q == LOAD_KEY) kl_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (reuse_hit) begin
                        data_d[8*DATA_BYTES-1 -: 8] = in_byte;
                    end else begin
                        sel_d = sel;
                        kl_d  = 1'b0;
                        key_d = '0;
                        key_d[8*KEY_MAX_BYTES-1 -: 8] = in_byte;
                    end
                end
                LOAD_KEY: if (accept) begin
                    for (int unsigned i = 0; i < KEY_MAX_BYTES; i++) begin
                        if (cnt_q == 6'(i)) key_d[8*(KEY_MAX_BYTES-1-i) +: 8] = in_byte;
                    end
                    if (key_last) kl_d = 1'b1;
                end
                LOAD_DATA: if (accept) begin
                    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                        if (cnt_q == 6'(i)) data_d[8*(DATA_BYTES-1-i) +: 8] = in_byte;
                    end
                    if (data_last) valid_d = 1'b1;
                end
                HOLD: if (out_ready) valid_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign out_data   = data_q;
    assign out_key    = key_q;
    assign out_sel    = sel_q;
    assign out_valid  = valid_q;
    assign key_loaded = kl_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: table of full loads plus flush and reset sequences.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sel;
    logic         reuse_key;
    logic         flush;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [255:0] out_key;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;
    logic         key_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   sel;
        logic         reuse;
        int           nkey;
        logic         stall;
        int           hold;
        logic [127:0] din;
        logic [255:0] exp_key;
        logic [127:0] exp_data;
        logic [1:0]   exp_sel;
    } vec_t;

    vec_t vecs[4];

    aes_block_loader #(.DATA_BYTES(16), .KEY_MAX_BYTES(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .reuse_key  (reuse_key),
        .flush      (flush),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_key    (out_key),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_loaded (key_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit first;
        first     = 1'b1;
        sel       = v.sel;
        reuse_key = v.reuse;
        out_ready = 1'b0;
        if (!v.reuse) begin
            for (int i = 0; i < v.nkey; i++) begin
                send_byte(8'(i));
                if (first) begin
                    sel       = ~v.sel;
                    reuse_key = 1'b0;
                    first     = 1'b0;
                end
                if (v.stall) idle_cycle();
            end
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(v.din[127-8*i -: 8]);
            if (first) begin
                sel       = ~v.sel;
                reuse_key = 1'b0;
                first     = 1'b0;
            end
            if (i == 14) check($sformatf("v%0d valid_early", idx), 256'(out_valid), 256'(0));
        end
        check($sformatf("v%0d out_valid", idx), 256'(out_valid), 256'(1));
        check($sformatf("v%0d in_ready_hold", idx), 256'(in_ready), 256'(0));
        check($sformatf("v%0d out_key", idx), out_key, v.exp_key);
        check($sformatf("v%0d out_data", idx), 256'(out_data), 256'(v.exp_data));
        check($sformatf("v%0d out_sel", idx), 256'(out_sel), 256'(v.exp_sel));
        check($sformatf("v%0d key_loaded", idx), 256'(key_loaded), 256'(1));
        for (int h = 0; h < v.hold; h++) begin
            idle_cycle();
            check($sformatf("v%0d hold_valid", idx), 256'(out_valid), 256'(1));
            check($sformatf("v%0d hold_ready", idx), 256'(in_ready), 256'(0));
            check($sformatf("v%0d hold_key", idx), out_key, v.exp_key);
            check($sformatf("v%0d hold_data", idx), 256'(out_data), 256'(v.exp_data));
        end
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
        check($sformatf("v%0d valid_drop", idx), 256'(out_valid), 256'(0));
        check($sformatf("v%0d idle_ready", idx), 256'(in_ready), 256'(1));
        check($sformatf("v%0d key_kept", idx), out_key, v.exp_key);
    endtask

    initial begin
        vecs[0] = '{sel: 2'b00, reuse: 1'b0, nkey: 16, stall: 1'b0, hold: 0,
                    din: 128'h00112233445566778899aabbccddeeff,
                    exp_key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    exp_data: 128'h00112233445566778899aabbccddeeff, exp_sel: 2'b00};
        vecs[1] = '{sel: 2'b10, reuse: 1'b0, nkey: 32, stall: 1'b1, hold: 5,
                    din: 128'h00112233445566778899aabbccddeeff,
                    exp_key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    exp_data: 128'h00112233445566778899aabbccddeeff, exp_sel: 2'b10};
        vecs[2] = '{sel: 2'b01, reuse: 1'b0, nkey: 24, stall: 1'b0, hold: 1,
                    din: 128'h3243f6a8885a308d313198a2e0370734,
                    exp_key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    exp_data: 128'h3243f6a8885a308d313198a2e0370734, exp_sel: 2'b01};
        vecs[3] = '{sel: 2'b00, reuse: 1'b1, nkey: 0, stall: 1'b0, hold: 2,
                    din: 128'hffeeddccbbaa99887766554433221100,
                    exp_key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    exp_data: 128'hffeeddccbbaa99887766554433221100, exp_sel: 2'b01};

        reset     = 1'b0;
        sel       = 2'b00;
        reuse_key = 1'b0;
        flush     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 256'(out_valid), 256'(0));
        check("rst key_loaded", 256'(key_loaded), 256'(0));
        check("rst out_key", out_key, 256'(0));
        check("rst out_data", 256'(out_data), 256'(0));
        check("rst out_sel", 256'(out_sel), 256'(0));
        check("rst in_ready", 256'(in_ready), 256'(1));
        reset = 1'b1;
        idle_cycle();

        for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

        // Flush part-way through a 128-bit key, with a byte offered in the flush cycle.
        sel = 2'b00;
        for (int i = 0; i < 7; i++) send_byte(8'(i));
        in_byte  = 8'haa;
        in_valid = 1'b1;
        flush    = 1'b1;
        idle_cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fk key_loaded", 256'(key_loaded), 256'(0));
        check("fk in_ready", 256'(in_ready), 256'(1));
        check("fk out_valid", 256'(out_valid), 256'(0));
        check("fk out_key", out_key, {56'h00010203040506, 200'h0});
        run_vec(vecs[0], 10);

        // Flush during a reuse data load keeps the key and never validates.
        reuse_key = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h50 + 8'(i));
            reuse_key = 1'b0;
        end
        in_byte  = 8'h77;
        in_valid = 1'b1;
        flush    = 1'b1;
        idle_cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fd key_loaded", 256'(key_loaded), 256'(1));
        check("fd out_valid", 256'(out_valid), 256'(0));
        check("fd out_data", 256'(out_data), 256'(128'h50515253545556575899aabbccddeeff));
        check("fd out_key", out_key, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        idle_cycle();
        check("fd out_valid_later", 256'(out_valid), 256'(0));

        // Asynchronous reset between clock edges during a data load.
        reuse_key = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h60 + 8'(i));
            reuse_key = 1'b0;
        end
        in_valid = 1'b1;
        in_byte  = 8'h65;
        #2;
        reset = 1'b0;
        #1;
        check("ar out_data", 256'(out_data), 256'(0));
        check("ar out_key", out_key, 256'(0));
        check("ar out_sel", 256'(out_sel), 256'(0));
        check("ar out_valid", 256'(out_valid), 256'(0));
        check("ar key_loaded", 256'(key_loaded), 256'(0));
        check("ar in_ready", 256'(in_ready), 256'(1));
        in_valid = 1'b0;
        idle_cycle();
        reset = 1'b1;
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
